// File: rtl/result_writer_pkg.sv
// result_writer_pkg: shared types and default widths for the result writer.
//   state_t   : writer FSM state encoding (IDLE/RUN/FLUSH/DONE)
//   RW_DATA_W : result word width, matches the accelerator wr_data
//   RW_ADDR_W : result memory address width
package result_writer_pkg;
   localparam int RW_DATA_W = 21;
   localparam int RW_ADDR_W = 10;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/result_writer_fifo.sv
// result_fifo: first-word-fall-through FIFO with synchronous clear.
//   clk/rst    : clock, asynchronous active-low reset
//   clr        : synchronous clear of pointers and occupancy
//   push/din   : write din (caller never pushes when full without popping)
//   pop/dout   : dout is the head word; pop consumes it (never when empty)
//   full/empty : occupancy flags
module result_fifo #(
   parameter int DATA_W = 21,
   parameter int DEPTH  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [DATA_W-1:0] ram [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      rd_d  = clr ? '0 : pop ? nxt(rd_q) : rd_q;
      wr_d  = clr ? '0 : push ? nxt(wr_q) : wr_q;
      cnt_d = clr ? '0 : cnt_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   always_ff @(posedge clk)
      if (push && !clr) ram[wr_q] <= din;
   assign dout  = ram[rd_q];
   assign full  = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
endmodule

// File: rtl/result_writer.sv
// result_writer: buffers accelerator result words and drains them to a stallable result memory.
//   clk/rst                   : clock, asynchronous active-low reset
//   start                     : one-cycle pulse, begins (or restarts) a run
//   wr_req/wr_data            : accelerator result strobe and word (no back-pressure)
//   acc_done                  : accelerator done level
//   mem_we/mem_addr/mem_wdata : memory write request, held until mem_ready
//   mem_ready                 : memory accepts the write this cycle
//   words_written             : words committed this run
//   overflow                  : sticky, a word was dropped on a full buffer
//   done                      : run complete, all captured words committed
//   checksum                  : sum of committed words (only with RESULT_WRITER_CHECKSUM_EN)
module result_writer
   import result_writer_pkg::*;
#(
   parameter int                DATA_W    = RW_DATA_W,
   parameter int                DEPTH     = 8,
   parameter int                ADDR_W    = RW_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              acc_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic [ADDR_W:0]   words_written,
   output logic              overflow,
   output logic              done
`ifdef RESULT_WRITER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);
   state_t            st_q, st_d;
   logic              mem_we_q, mem_we_d, ovf_q, ovf_d, done_q, done_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, head;
   logic [ADDR_W:0]   words_q, words_d;
   logic              cap, acc, pop, push, drop, full, empty;
   // The drain register is the oldest buffered entry, so the FIFO behind it
   // holds DEPTH-1 words and the pair together holds exactly DEPTH.
   result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH - 1)) u_fifo (
      .clk(clk), .rst(rst), .clr(start), .push(push), .pop(pop),
      .din(wr_data), .dout(head), .full(full), .empty(empty)
   );
   always_comb begin
      cap  = (st_q == RUN || st_q == FLUSH) && wr_req && !start;
      acc  = mem_we_q && mem_ready;
      pop  = !empty && (!mem_we_q || mem_ready) && !start;
      // A full buffer frees a slot when the drain register refills the same cycle.
      push = cap && (!full || pop);
      drop = cap && full && !pop;
      mem_we_d    = start ? 1'b0 : pop ? 1'b1 : acc ? 1'b0 : mem_we_q;
      mem_wdata_d = pop ? head : mem_wdata_q;
      mem_addr_d  = start ? BASE_ADDR : acc ? mem_addr_q + 1'b1 : mem_addr_q;
      words_d     = start ? '0 : acc ? words_q + 1'b1 : words_q;
      ovf_d       = start ? 1'b0 : ovf_q | drop;
      st_d        = start ? RUN :
                    (st_q == RUN && acc_done) ? FLUSH :
                    (st_q == FLUSH && empty && !mem_we_q && !push) ? DONE : st_q;
      done_d      = st_d == DONE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st_q        <= IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
         words_q     <= '0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         st_q        <= st_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         words_q     <= words_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign words_written = words_q;
   assign overflow      = ovf_q;
   assign done          = done_q;
`ifdef RESULT_WRITER_CHECKSUM_EN
   logic [DATA_W-1:0] chk_q, chk_d;
   always_comb chk_d = start ? '0 : acc ? chk_q + mem_wdata_q : chk_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) chk_q <= '0;
      else chk_q <= chk_d;
   assign checksum = chk_q;
`endif
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: scoreboard bench for result_writer (10-bit and 2-bit address instances).
module tb_result_writer;
   logic        clk = 0, rst = 0, start = 0, wr_req = 0, acc_done = 0, mem_ready = 1;
   logic [20:0] wr_data = '0;
   logic        we_a, ovf_a, done_a, we_b, ovf_b, done_b;
   logic [9:0]  addr_a;
   logic [1:0]  addr_b;
   logic [20:0] wd_a, wd_b;
   logic [10:0] words_a;
   logic [2:0]  words_b;
   logic [30:0] qa[$], qb[$];
   int passed = 0, total = 0, exp_n = 0;
`ifdef RESULT_WRITER_CHECKSUM_EN
   logic [20:0] chk_a, chk_b;
`endif
   result_writer u_a (
      .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .wr_data(wr_data),
      .acc_done(acc_done), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
      .mem_ready(mem_ready), .words_written(words_a), .overflow(ovf_a), .done(done_a)
`ifdef RESULT_WRITER_CHECKSUM_EN
      , .checksum(chk_a)
`endif
   );
   result_writer #(.ADDR_W(2)) u_b (
      .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .wr_data(wr_data),
      .acc_done(acc_done), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
      .mem_ready(mem_ready), .words_written(words_b), .overflow(ovf_b), .done(done_b)
`ifdef RESULT_WRITER_CHECKSUM_EN
      , .checksum(chk_b)
`endif
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic expect_word(input logic [20:0] d);
      logic [31:0] n;
      n = exp_n;
      qa.push_back({n[9:0], d});
      qb.push_back({8'd0, n[1:0], d});
      exp_n++;
   endtask
   task automatic do_start();
      start = 1;
      exp_n = 0;
      tick();
      start = 0;
   endtask
   task automatic strobe(input logic [20:0] d, input bit expected);
      wr_req  = 1;
      wr_data = d;
      if (expected) expect_word(d);
      tick();
      wr_req = 0;
   endtask
   task automatic pulse_done();
      acc_done = 1;
      tick();
      acc_done = 0;
   endtask
   task automatic wait_done(input int max);
      int k = 0;
      while (!(done_a && done_b) && k < max) begin
         tick();
         k++;
      end
      check("done_a", done_a, 1);
      check("done_b", done_b, 1);
      check("queue_a_drained", qa.size(), 0);
      check("queue_b_drained", qb.size(), 0);
   endtask
   // Scoreboard monitors: compare each accepted write and hold stability while stalled.
   logic [9:0]  hold_addr_a;
   logic [20:0] hold_data_a;
   bit          stalled_a = 0;
   always @(negedge clk) begin
      logic [30:0] e;
      if (rst && we_a) begin
         if (stalled_a) begin
            check("stall_addr_a", addr_a, hold_addr_a);
            check("stall_data_a", wd_a, hold_data_a);
         end
         if (mem_ready) begin
            stalled_a = 0;
            if (qa.size() == 0) begin
               total++;
               $display("FAIL unexpected_write_a: addr %0h data %0h, none expected", addr_a, wd_a);
            end else begin
               e = qa.pop_front();
               check("addr_a", addr_a, e[30:21]);
               check("data_a", wd_a, e[20:0]);
            end
         end else begin
            stalled_a   = 1;
            hold_addr_a = addr_a;
            hold_data_a = wd_a;
         end
      end else stalled_a = 0;
   end
   always @(negedge clk) begin
      logic [30:0] e;
      if (rst && we_b && mem_ready) begin
         if (qb.size() == 0) begin
            total++;
            $display("FAIL unexpected_write_b: addr %0h data %0h, none expected", addr_b, wd_b);
         end else begin
            e = qb.pop_front();
            check("addr_b", addr_b, e[22:21]);
            check("data_b", wd_b, e[20:0]);
         end
      end
   end
   initial begin
      logic [20:0] basic [4];
      basic = '{21'h00001, 21'h00002, 21'h1FFFFF, 21'h0ABCD};
      repeat (2) tick();
      check("rst_we", we_a, 0);
      check("rst_addr", addr_a, 0);
      check("rst_wdata", wd_a, 0);
      check("rst_words", words_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_done", done_a, 0);
      rst = 1;
      tick();
      // basic run with latency checks
      mem_ready = 1;
      do_start();
      for (int i = 0; i < 4; i++) begin
         strobe(basic[i], 1);
         if (i == 0) check("lat_capture", we_a, 0);
         if (i == 1) check("lat_present", we_a, 1);
      end
      pulse_done();
      wait_done(50);
      check("basic_words", words_a, 4);
      check("basic_ovf", ovf_a, 0);
`ifdef RESULT_WRITER_CHECKSUM_EN
      check("basic_checksum", chk_a, 21'h00ABCF);
`endif
      // back-pressure: mem_ready low 5 cycles per accepted write
      do_start();
      fork
         begin
            for (int i = 0; i < 4; i++) strobe(basic[i], 1);
            pulse_done();
         end
         begin
            for (int k = 0; k < 8; k++) begin
               mem_ready = 0;
               repeat (5) tick();
               mem_ready = 1;
               tick();
            end
         end
      join
      wait_done(50);
      check("bp_words", words_a, 4);
      check("bp_ovf", ovf_a, 0);
      // overflow: 10 strobes into 8 slots while the memory stalls
      do_start();
      mem_ready = 0;
      for (int i = 0; i < 10; i++) strobe(21'h100 + 21'(i), i < 8);
      tick();
      check("ovf_sticky", ovf_a, 1);
      pulse_done();
      mem_ready = 1;
      wait_done(50);
      check("ovf_words", words_a, 8);
      check("ovf_final", ovf_a, 1);
      // full boundary: push and accept on the same edge while full
      do_start();
      mem_ready = 0;
      for (int i = 0; i < 8; i++) strobe(21'h200 + 21'(i), 1);
      mem_ready = 1;
      strobe(21'h0999, 1);
      pulse_done();
      wait_done(50);
      check("full_ovf", ovf_a, 0);
      check("full_words", words_a, 9);
      // reset during FLUSH with 3 words queued
      do_start();
      mem_ready = 0;
      for (int i = 0; i < 3; i++) strobe(21'h300 + 21'(i), 0);
      pulse_done();
      tick();
      rst = 0;
      #1;
      check("mid_rst_we", we_a, 0);
      check("mid_rst_addr", addr_a, 0);
      check("mid_rst_wdata", wd_a, 0);
      check("mid_rst_words", words_a, 0);
      check("mid_rst_ovf", ovf_a, 0);
      check("mid_rst_done", done_a, 0);
      tick();
      rst = 1;
      mem_ready = 1;
      tick();
      do_start();
      strobe(21'h0055, 1);
      strobe(21'h0066, 1);
      pulse_done();
      wait_done(50);
      check("post_rst_words", words_a, 2);
      // wrap on the 2-bit instance, then restart from DONE
      do_start();
      for (int i = 0; i < 6; i++) strobe(21'h400 + 21'(i), 1);
      pulse_done();
      wait_done(50);
      check("wrap_words_b", words_b, 6);
      check("wrap_words_a", words_a, 6);
      do_start();
      check("restart_done", done_a, 0);
      check("restart_words", words_a, 0);
      check("restart_addr", addr_a, 0);
`ifdef RESULT_WRITER_CHECKSUM_EN
      check("restart_checksum", chk_a, 0);
`endif
      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Downstream consumer of the accelerator wrapper's result stream (wr_req strobe plus 21-bit wr_data).
- Captures every strobed word into a small FIFO and drains it to a single-port result memory at incrementing addresses; the memory may stall.
- Asserts its own done only after the accelerator reports done and every captured word is in memory.

Parameters:
DATA_W, 21, result word width (matches accelerator wr_data)
DEPTH, 8, FIFO entries, power of two, at least 2
ADDR_W, 10, result memory address width
BASE_ADDR, 0, first write address after start

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse, begins a run (same pulse that drives the accelerator)
wr_req  input  1  accelerator strobe, one word per high cycle, cannot be back-pressured
wr_data  input  DATA_W  accelerator result word, valid when wr_req=1
acc_done  input  1  accelerator done level
mem_we  output  1  memory write request
mem_addr  output  ADDR_W  memory write address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory accepts the write this cycle when mem_we=1
words_written  output  ADDR_W+1  count of words committed this run
overflow  output  1  sticky: a word was dropped on a full FIFO
done  output  1  run complete

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_written=0, overflow=0, done=0.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start: clear FIFO pointers, words_written, overflow and done; load mem_addr=BASE_ADDR.
  - RUN -> FLUSH on the first cycle acc_done=1 is sampled.
  - FLUSH -> DONE when the FIFO is empty and no write is outstanding.
  - DONE holds done=1 until start, which behaves exactly as start from IDLE.
  - start in RUN or FLUSH aborts the current run and restarts it; uncommitted data is discarded.
- Capture: in RUN and FLUSH, wr_req=1 with FIFO not full pushes wr_data. wr_req outside RUN/FLUSH is ignored.
- Overflow: wr_req=1 with FIFO full drops the word and sets overflow; it stays set until the next start.
- Simultaneous push and pop on a full FIFO: the pop frees a slot the same cycle, so the push is accepted and overflow is not set. Same-cycle push and pop on a non-empty FIFO leaves occupancy unchanged.
- Drain: mem_we/mem_wdata are registered from the FIFO head.
  - Minimum latency is 2 cycles from wr_req to mem_we (capture edge, then present edge).
  - Once asserted, mem_we, mem_addr and mem_wdata hold stable until the cycle mem_ready=1.
  - On that edge: pop the head, mem_addr+1, words_written+1.
  - If the FIFO still holds data, mem_we stays high with the next word (one word per cycle at full rate); otherwise mem_we drops.
- mem_addr wraps modulo 2^ADDR_W. words_written does not wrap (ADDR_W+1 bits).
- done is registered: it rises one cycle after the FIFO empties in FLUSH and stays high in DONE.
- acc_done=1 while the FIFO is empty and no write is pending: FLUSH lasts exactly one cycle.

Optional Feature:
- Macro: RESULT_WRITER_CHECKSUM_EN.
- When defined, adds output checksum [DATA_W-1:0]:
  - modulo-2^DATA_W sum of every word committed to memory this run;
  - cleared on reset and on start;
  - updated on each accepted write; final once done=1.
- When undefined, the port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE/RUN/FLUSH/DONE);
  - DATA_W default 21, matching the accelerator;
  - memory address width constant.
- One sub-module, result_fifo:
  - parameterised DATA_W/DEPTH, async active-low reset;
  - ports push, pop, din, dout, full, empty, plus a synchronous clear for start;
  - first-word-fall-through.
- Top level holds the FSM, drain register, counters and optional checksum.

Test Plan:
- Basic run: start, 4 strobes (0x00001, 0x00002, 0x1FFFFF, 0x0ABCD), mem_ready tied 1, then acc_done -> 4 writes to addr 0..3 with those values; words_written=4; done=1; overflow=0; checksum=0x00ABCF (0x1FFFFF + 0x00001 wraps).
- Back-pressure: same stream with mem_ready low for 5 cycles per write -> mem_we/addr/data stable while stalled; no loss; overflow=0.
- Overflow: DEPTH=8, mem_ready=0, 10 consecutive strobes, then release -> overflow=1; exactly 8 words written (first 8 values); words_written=8; done after acc_done.
- Full boundary: FIFO full while mem_ready=1 and wr_req=1 in the same cycle -> word accepted; overflow stays 0.
- Reset mid-run: rst low during FLUSH with 3 words queued -> all outputs return to reset values immediately; a new start runs cleanly from BASE_ADDR.
- Wrap and restart: ADDR_W=2, 6 words -> addresses 0,1,2,3,0,1; words_written=6. A second start in DONE clears done, counters and checksum.
